// File: rtl/saturn_phase_sequencer_pkg.sv
// Shared definitions for the Saturn phase sequencer: state encodings, the
// default channel-to-phase map and the channel index names of the core.
package saturn_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STEP_WAIT = 2'd1,
        ST_STEP_RUN  = 2'd2,
        ST_HALT      = 2'd3
    } seq_state_t;

    // Two bits per channel, channel 0 at the LSB.
    localparam logic [19:0] DEFAULT_CH_PHASE = 20'hFE940;

    localparam int CH_ALU_DUMP  = 0;
    localparam int CH_DBG       = 1;
    localparam int CH_BUS_SEND  = 2;
    localparam int CH_BUS_RECV  = 3;
    localparam int CH_ALU_PREP  = 4;
    localparam int CH_ALU_CALC  = 5;
    localparam int CH_INST_DEC  = 6;
    localparam int CH_ALU_INIT  = 7;
    localparam int CH_ALU_SAVE  = 8;
    localparam int CH_INST_EXEC = 9;

endpackage

// File: rtl/saturn_step_edge.sv
// Registers the step request and emits a one-clock pulse on its rising edge.
module saturn_step_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_step,
    output logic step_pulse
);

    logic step_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            step_q     <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_q     <= i_step;
            step_pulse <= i_step & ~step_q;
        end
    end

endmodule

// File: rtl/saturn_phase_sequencer.sv
// Multi-phase clock-enable sequencer with cycle counter, single-step and halt.
// Optional SATURN_SEQ_TRACE_EN adds simulation-only cycle/phase and halt traces.
module saturn_phase_sequencer
    import saturn_phase_sequencer_pkg::*;
#(
    parameter int PHASES   = 4,
    parameter int CHANNELS = 10,
    parameter int CTR_W    = 32,
    parameter logic [CHANNELS*$clog2(PHASES)-1:0] CH_PHASE = DEFAULT_CH_PHASE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_step_mode,
    input  logic                       i_step,
    input  logic                       i_halt_req,
    input  logic                       i_max_en,
    input  logic [CTR_W-1:0]           i_max_cycle,
    output logic [CHANNELS-1:0]        o_en,
    output logic [$clog2(PHASES)-1:0]  o_phase,
    output logic [CTR_W-1:0]           o_cycle,
    output logic [1:0]                 o_state,
    output logic                       o_halt,
    output logic                       o_out_of_cycles
);

    localparam int PH_W = $clog2(PHASES);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);

    seq_state_t          state, state_nxt;
    logic [PH_W-1:0]     phase, phase_nxt;
    logic [CTR_W-1:0]    cycle, cycle_nxt;
    logic [CHANNELS-1:0] en, en_nxt, en_match;
    logic                oor, oor_nxt;
    logic                step_pulse;
    logic                advance;
    logic                at_last;
    logic [CTR_W-1:0]    limit_target;
    logic                limit_hit;
    logic                halt_go;

    saturn_step_edge u_step_edge (
        .clk        (clk),
        .reset      (reset),
        .i_step     (i_step),
        .step_pulse (step_pulse)
    );

    assign at_last      = (phase == LAST_PHASE);
    assign limit_target = i_max_cycle + CTR_W'(1);
    assign limit_hit    = i_max_en && (cycle == limit_target);
    assign halt_go      = i_halt_req || limit_hit;

    always_comb begin
        en_match = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            en_match[c] = (phase == CH_PHASE[c*PH_W +: PH_W]);
        end
    end

    // Halt overrides every other transition, and its entry edge does not advance.
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            ST_RUN: begin
                advance = 1'b1;
                if (at_last && i_step_mode) begin
                    state_nxt = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (step_pulse) begin
                    advance   = 1'b1;
                    state_nxt = ST_STEP_RUN;
                end
            end
            ST_STEP_RUN: begin
                advance = 1'b1;
                if (at_last) begin
                    state_nxt = i_step_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
        if (halt_go) begin
            state_nxt = ST_HALT;
            advance   = 1'b0;
        end
    end

    always_comb begin
        phase_nxt = phase;
        cycle_nxt = cycle;
        en_nxt    = '0;
        oor_nxt   = oor;
        if (advance) begin
            phase_nxt = at_last ? '0 : phase + PH_W'(1);
            cycle_nxt = cycle + CTR_W'(phase == '0);
            en_nxt    = en_match;
        end
        if (halt_go && limit_hit && (state != ST_HALT)) begin
            oor_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
            phase <= LAST_PHASE;
            cycle <= '1;
            en    <= '0;
            oor   <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            cycle <= cycle_nxt;
            en    <= en_nxt;
            oor   <= oor_nxt;
        end
    end

`ifdef SATURN_SEQ_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            if (advance && (phase == '0)) begin
                $display("[saturn_seq] cycle %0d phase %0d", cycle, phase);
            end
            if (halt_go && (state != ST_HALT)) begin
                if (limit_hit) begin
                    $display("[saturn_seq] *** HALT: OUT OF CYCLES at cycle %0d ***", cycle);
                end else begin
                    $display("[saturn_seq] *** HALT: HALT REQUEST at cycle %0d ***", cycle);
                end
            end
        end
    end
`else
    // Trace output compiled out; behaviour is unchanged.
`endif

    assign o_en            = en;
    assign o_phase         = phase;
    assign o_cycle         = cycle;
    assign o_state         = state;
    assign o_halt          = (state == ST_HALT);
    assign o_out_of_cycles = oor;

endmodule
